// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multicycle core control path: FSM states,
// ALU operation codes, opcode/funct encodings and operand-select encodings.
package core_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_EXEC_I,
      ST_MEM_ADDR,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_WB_ALU,
      ST_WB_MEM,
      ST_BRANCH,
      ST_TRAP
   } state_t;

   localparam logic [3:0] ALUOP_ADD = 4'b0010;
   localparam logic [3:0] ALUOP_SUB = 4'b0110;
   localparam logic [3:0] ALUOP_AND = 4'b0000;
   localparam logic [3:0] ALUOP_OR  = 4'b0001;
   localparam logic [3:0] ALUOP_SRL = 4'b1010;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SRL     = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_RS1   = 2'b01;
   localparam logic [1:0] SRC_A_OLDPC = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   // Picks the state following DECODE; anything outside the supported subset traps.
   function automatic state_t decode_target(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
      state_t nxt;
      nxt = ST_TRAP;
      case (opcode)
         OPC_RTYPE: begin
            if (funct7 == F7_BASE &&
                (funct3 == F3_ADD_SUB || funct3 == F3_AND ||
                 funct3 == F3_OR || funct3 == F3_SRL))
               nxt = ST_EXEC_R;
            else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)
               nxt = ST_EXEC_R;
         end
         OPC_OPIMM:  if (funct3 == F3_ADD_SUB) nxt = ST_EXEC_I;
         OPC_LOAD:   if (funct3 == F3_WORD)    nxt = ST_MEM_ADDR;
         OPC_STORE:  if (funct3 == F3_WORD)    nxt = ST_MEM_ADDR;
         OPC_BRANCH: if (funct3 == F3_BEQ)     nxt = ST_BRANCH;
         default:    nxt = ST_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation selection from control state and funct fields.
// Kept separate so a pipelined core can reuse the same funct mapping.
module alu_op_decode
   import core_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_op
);

   // Register ops follow funct; branches compare by subtraction; everything else adds.
   always_comb begin
      alu_op = ALUOP_ADD;
      case (state)
         ST_EXEC_R: begin
            case (funct3)
               F3_ADD_SUB: alu_op = (funct7 == F7_ALT) ? ALUOP_SUB : ALUOP_ADD;
               F3_AND:     alu_op = ALUOP_AND;
               F3_OR:      alu_op = ALUOP_OR;
               F3_SRL:     alu_op = ALUOP_SRL;
               default:    alu_op = ALUOP_ADD;
            endcase
         end
         ST_BRANCH: alu_op = ALUOP_SUB;
         default:   alu_op = ALUOP_ADD;
      endcase
   end

endmodule

// File: rtl/alu_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset core: sequences fetch, decode,
// execute, memory and write-back over a shared ALU and memory port.
module alu_multicycle_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         instr,
   input  logic                zero,
   input  logic                mem_ready,
   output logic [3:0]          alu_op,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                pc_en,
   output logic                pc_source,
   output logic                ir_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                i_or_d,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   state_t              state_q;
   state_t              state_d;
   logic                retire_now;
   logic                illegal_q;
   logic [RETIRE_W-1:0] retired_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_instr_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // Register and immediate fields belong to the datapath, not the controller.
   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   alu_op_decode u_alu_op_decode (
      .state  (state_q),
      .funct3 (funct3),
      .funct7 (funct7),
      .alu_op (alu_op)
   );

   // State register; reset aborts whatever instruction is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_INIT;
      else       state_q <= state_d;
   end

   // Retirement counter and sticky illegal flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (retire_now)          retired_q <= retired_q + RETIRE_W'(1);
         if (state_d == ST_TRAP)  illegal_q <= 1'b1;
      end
   end

   // Next-state and Moore outputs; pc_en/ir_write in FETCH and pc_en in BRANCH are combinational.
   always_comb begin
      state_d    = state_q;
      retire_now = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      pc_en      = 1'b0;
      pc_source  = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            state_d   = decode_target(opcode, funct3, funct7);
         end
         ST_EXEC_R: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            state_d   = ST_WB_ALU;
         end
         ST_EXEC_I: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = ST_WB_ALU;
         end
         ST_MEM_ADDR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
         end
         ST_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_d = ST_WB_MEM;
         end
         ST_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               state_d    = ST_FETCH;
               retire_now = 1'b1;
            end
         end
         ST_WB_ALU: begin
            reg_write  = 1'b1;
            state_d    = ST_FETCH;
            retire_now = 1'b1;
         end
         ST_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = ST_FETCH;
            retire_now = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            pc_source  = 1'b1;
            pc_en      = zero;
            state_d    = ST_FETCH;
            retire_now = 1'b1;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_INIT;
      endcase
   end

   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Directed bench for alu_multicycle_ctrl: walks each instruction class
// through its state sequence and compares outputs with hand-derived values.
module tb_alu_multicycle_ctrl;
   import core_ctrl_pkg::*;

   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_SUB  = 32'h403100B3;
   localparam logic [31:0] I_AND  = 32'h003170B3;
   localparam logic [31:0] I_OR   = 32'h003160B3;
   localparam logic [31:0] I_SRL  = 32'h003150B3;
   localparam logic [31:0] I_ADDI = 32'h00110093;
   localparam logic [31:0] I_LW   = 32'h00012083;
   localparam logic [31:0] I_SW   = 32'h00312023;
   localparam logic [31:0] I_BEQ  = 32'h00310063;
   localparam logic [31:0] I_JAL  = 32'h0000006F;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  alu_op;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic        pc_en, pc_source, ir_write, mem_read, mem_write;
   logic        i_or_d, reg_write, mem_to_reg, illegal;
   logic [31:0] retired;

   // {pc_en, pc_source, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg}
   logic [7:0] ens;
   logic [3:0] sels;
   assign ens  = {pc_en, pc_source, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg};
   assign sels = {alu_src_a, alu_src_b};

   int total = 0;
   int bad   = 0;

   alu_multicycle_ctrl #(.RETIRE_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_en      (pc_en),
      .pc_source  (pc_source),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .i_or_d     (i_or_d),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts in FETCH; runs one R-type through EXEC_R and WB_ALU back to FETCH.
   task automatic run_r(input logic [31:0] ins, input logic [3:0] op, input logic [31:0] ret);
      instr = ins;
      #1;
      check("r_fetch_st", dut.state_q, ST_FETCH);
      check("r_fetch_en", ens, 8'hB0);
      check("r_fetch_sel", sels, 4'b0001);
      tick;
      check("r_dec_st", dut.state_q, ST_DECODE);
      check("r_dec_sel", sels, 4'b1010);
      check("r_dec_en", ens, 8'h00);
      tick;
      check("r_exec_st", dut.state_q, ST_EXEC_R);
      check("r_exec_op", alu_op, op);
      check("r_exec_sel", sels, 4'b0100);
      check("r_exec_en", ens, 8'h00);
      tick;
      check("r_wb_st", dut.state_q, ST_WB_ALU);
      check("r_wb_en", ens, 8'h02);
      tick;
      check("r_done_st", dut.state_q, ST_FETCH);
      check("r_done_ret", retired, ret);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_st", dut.state_q, ST_INIT);
      check("rst_en", ens, 8'h00);
      check("rst_op", alu_op, 4'b0010);
      check("rst_sel", sels, 4'b0000);
      check("rst_ret", retired, 0);
      check("rst_ill", illegal, 0);

      reset = 1'b0; instr = I_ADD;
      #1;
      check("init_st", dut.state_q, ST_INIT);
      check("init_en", ens, 8'h00);
      tick;
      check("first_fetch_ret", retired, 0);

      run_r(I_ADD, 4'b0010, 1);
      run_r(I_SUB, 4'b0110, 2);
      run_r(I_AND, 4'b0000, 3);
      run_r(I_OR,  4'b0001, 4);
      run_r(I_SRL, 4'b1010, 5);

      // addi
      instr = I_ADDI;
      tick;
      check("addi_dec_st", dut.state_q, ST_DECODE);
      tick;
      check("addi_exec_st", dut.state_q, ST_EXEC_I);
      check("addi_exec_sel", sels, 4'b0110);
      check("addi_exec_op", alu_op, 4'b0010);
      tick;
      check("addi_wb_en", ens, 8'h02);
      tick;
      check("addi_ret", retired, 6);

      // fetch stall: nothing loads while memory is busy
      mem_ready = 1'b0;
      #1;
      check("fstall_en", ens, 8'h10);
      tick;
      check("fstall_st", dut.state_q, ST_FETCH);
      check("fstall_en2", ens, 8'h10);
      mem_ready = 1'b1;
      #1;
      check("fstall_go_en", ens, 8'hB0);

      // lw with three wait cycles in MEM_RD: 8 cycles in total
      instr = I_LW;
      tick;
      check("lw_dec_st", dut.state_q, ST_DECODE);
      tick;
      check("lw_addr_st", dut.state_q, ST_MEM_ADDR);
      check("lw_addr_sel", sels, 4'b0110);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("lw_wait_st", dut.state_q, ST_MEM_RD);
         check("lw_wait_en", ens, 8'h14);
      end
      tick;
      mem_ready = 1'b1;
      #1;
      check("lw_rd_st", dut.state_q, ST_MEM_RD);
      check("lw_rd_en", ens, 8'h14);
      tick;
      check("lw_wb_st", dut.state_q, ST_WB_MEM);
      check("lw_wb_en", ens, 8'h03);
      tick;
      check("lw_done_st", dut.state_q, ST_FETCH);
      check("lw_ret", retired, 7);

      // beq taken
      instr = I_BEQ; zero = 1'b1;
      tick;
      check("beq_dec_st", dut.state_q, ST_DECODE);
      tick;
      check("beq1_st", dut.state_q, ST_BRANCH);
      check("beq1_en", ens, 8'hC0);
      check("beq1_op", alu_op, 4'b0110);
      check("beq1_sel", sels, 4'b0100);
      tick;
      check("beq1_ret", retired, 8);

      // beq not taken; pc_en follows zero combinationally
      zero = 1'b0;
      tick;
      tick;
      check("beq0_st", dut.state_q, ST_BRANCH);
      check("beq0_en", ens, 8'h40);
      zero = 1'b1;
      #1;
      check("beq0_zero_en", ens, 8'hC0);
      zero = 1'b0;
      tick;
      check("beq0_ret", retired, 9);

      // jal is unsupported: trap and stay there
      instr = I_JAL;
      tick;
      check("jal_dec_st", dut.state_q, ST_DECODE);
      check("jal_dec_ill", illegal, 0);
      tick;
      check("jal_trap_st", dut.state_q, ST_TRAP);
      check("jal_trap_ill", illegal, 1);
      for (int i = 0; i < 20; i++) begin
         tick;
         check("trap_en", ens, 8'h00);
         check("trap_ill", illegal, 1);
      end
      check("trap_ret", retired, 9);
      #2 reset = 1'b1;
      #1;
      check("trap_rst_ill", illegal, 0);
      check("trap_rst_st", dut.state_q, ST_INIT);
      check("trap_rst_ret", retired, 0);

      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rel_st", dut.state_q, ST_INIT);
      tick;
      check("rel_fetch_st", dut.state_q, ST_FETCH);
      check("rel_fetch_ret", retired, 0);

      // sw interrupted by reset while mem_write is high
      instr = I_SW;
      tick;
      tick;
      check("sw_addr_st", dut.state_q, ST_MEM_ADDR);
      mem_ready = 1'b0;
      tick;
      check("sw_wr_st", dut.state_q, ST_MEM_WR);
      check("sw_wr_en", ens, 8'h0C);
      tick;
      check("sw_wait_en", ens, 8'h0C);
      #2 reset = 1'b1;
      #1;
      check("sw_abort_en", ens, 8'h00);
      check("sw_abort_st", dut.state_q, ST_INIT);
      check("sw_abort_ret", retired, 0);

      // complete sw: 4 cycles, then retired
      @(posedge clk);
      #1 reset = 1'b0; mem_ready = 1'b1;
      tick;
      check("sw2_fetch_st", dut.state_q, ST_FETCH);
      tick;
      tick;
      check("sw2_addr_st", dut.state_q, ST_MEM_ADDR);
      tick;
      check("sw2_wr_st", dut.state_q, ST_MEM_WR);
      check("sw2_wr_en", ens, 8'h0C);
      tick;
      check("sw2_done_st", dut.state_q, ST_FETCH);
      check("sw2_ret", retired, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
